// File: rtl/k12a_fetch_if.sv
// Fetch-stage bus: control/redirect inputs, byte-wide memory read port, and the
// program counter and instruction register views.
interface k12a_fetch_if;
  logic        fetch_start;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic        skip;
  logic        mem_ready;
  logic [7:0]  mem_data;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        inst_valid;
  logic        busy;

  modport master (
    output fetch_start, pc_load, pc_load_value, skip, mem_ready, mem_data,
    input  mem_addr, mem_rd, pc, inst, inst_valid, busy
  );

  modport slave (
    input  fetch_start, pc_load, pc_load_value, skip, mem_ready, mem_data,
    output mem_addr, mem_rd, pc, inst, inst_valid, busy
  );
endinterface

// File: rtl/k12a_fetch.sv
// Instruction fetch: owns the PC, reads two bytes (high first) from byte memory
// and assembles the 16-bit instruction register; handles jump loads and skips.
module k12a_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] RESET_INST = 16'h0000
) (
  input  logic         clock,
  input  logic         reset,
  k12a_fetch_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FETCH_HI, FETCH_LO} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] inst_q, inst_d;
  logic [7:0]  hi_q, hi_d;
  logic        vld_q, vld_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= RESET_INST;
      hi_q    <= 8'h00;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      hi_q    <= hi_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    hi_d    = hi_q;
    vld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.pc_load)          pc_d = bus.pc_load_value;
        else if (bus.skip)        pc_d = pc_q + 16'd2;
        else if (bus.fetch_start) state_d = FETCH_HI;
      end
      FETCH_HI: begin
        // A redirect wins over a completing byte; the partial fetch is dropped.
        if (bus.pc_load) begin
          pc_d    = bus.pc_load_value;
          state_d = IDLE;
        end else if (bus.mem_ready) begin
          hi_d    = bus.mem_data;
          pc_d    = pc_q + 16'd1;
          state_d = FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (bus.pc_load) begin
          pc_d    = bus.pc_load_value;
          state_d = IDLE;
        end else if (bus.mem_ready) begin
          inst_d  = {hi_q, bus.mem_data};
          pc_d    = pc_q + 16'd1;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_addr   = pc_q;
  assign bus.mem_rd     = (state_q != IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.pc         = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = vld_q;

endmodule

// File: tb/tb_k12a_fetch.sv
// Randomized bench for k12a_fetch against a transaction-level PC/inst model.
module tb_k12a_fetch;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  k12a_fetch_if bus();
  k12a_fetch dut (.clock(clock), .reset(reset), .bus(bus));

  logic [7:0] mem [0:65535];
  assign bus.mem_data = mem[bus.mem_addr];

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_pc, exp_inst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_in();
    bus.fetch_start   = 1'b0;
    bus.pc_load       = 1'b0;
    bus.skip          = 1'b0;
    bus.mem_ready     = 1'b0;
    bus.pc_load_value = 16'($urandom);
  endtask

  // Full fetch with whi/wlo wait states per byte phase.
  task automatic do_fetch(input int whi, input int wlo);
    int busy_n;
    logic [15:0] a0, a1, want;
    busy_n = 0;
    a0 = exp_pc;
    a1 = exp_pc + 16'd1;
    want = {mem[a0], mem[a1]};
    idle_in();
    bus.fetch_start = 1'b1;
    step();
    bus.fetch_start = 1'b0;
    for (int i = 0; i <= whi; i++) begin
      chk("hi_addr", bus.mem_addr, a0);
      chk("hi_rd", bus.mem_rd, 1);
      chk("hi_inst", bus.inst, exp_inst);
      busy_n += int'(bus.busy);
      bus.mem_ready = (i == whi);
      bus.skip = 1'($urandom);
      step();
    end
    bus.skip = 1'b0;
    for (int i = 0; i <= wlo; i++) begin
      chk("lo_addr", bus.mem_addr, a1);
      chk("lo_valid", bus.inst_valid, 0);
      chk("lo_inst", bus.inst, exp_inst);
      busy_n += int'(bus.busy);
      bus.mem_ready = (i == wlo);
      step();
    end
    bus.mem_ready = 1'b0;
    exp_inst = want;
    exp_pc   = a0 + 16'd2;
    chk("f_valid", bus.inst_valid, 1);
    chk("f_inst", bus.inst, exp_inst);
    chk("f_pc", bus.pc, exp_pc);
    chk("f_busy", bus.busy, 0);
    chk("f_busy_cycles", busy_n, 2 + whi + wlo);
    if ($urandom_range(0, 1) == 0) begin
      step();
      chk("f_valid_drop", bus.inst_valid, 0);
    end
  endtask

  // Abort an in-flight fetch with pc_load; lo_phase selects which byte phase.
  task automatic do_abort(input bit lo_phase, input int w, input logic [15:0] tgt);
    idle_in();
    bus.fetch_start = 1'b1;
    step();
    bus.fetch_start = 1'b0;
    if (lo_phase) begin
      bus.mem_ready = 1'b1;
      step();
    end
    bus.mem_ready = 1'b0;
    for (int i = 0; i < w; i++) step();
    bus.pc_load       = 1'b1;
    bus.pc_load_value = tgt;
    bus.mem_ready     = 1'($urandom);
    bus.skip          = 1'($urandom);
    step();
    idle_in();
    exp_pc = tgt;
    chk("ab_busy", bus.busy, 0);
    chk("ab_pc", bus.pc, exp_pc);
    chk("ab_inst", bus.inst, exp_inst);
    chk("ab_valid", bus.inst_valid, 0);
    step();
    chk("ab_valid2", bus.inst_valid, 0);
    chk("ab_pc2", bus.pc, exp_pc);
  endtask

  task automatic do_load(input logic [15:0] tgt);
    idle_in();
    bus.pc_load       = 1'b1;
    bus.pc_load_value = tgt;
    bus.skip          = 1'($urandom);
    bus.fetch_start   = 1'($urandom);
    step();
    idle_in();
    exp_pc = tgt;
    chk("ld_pc", bus.pc, exp_pc);
    chk("ld_busy", bus.busy, 0);
  endtask

  task automatic do_skip();
    idle_in();
    bus.skip        = 1'b1;
    bus.fetch_start = 1'($urandom);
    step();
    idle_in();
    exp_pc = exp_pc + 16'd2;
    chk("sk_pc", bus.pc, exp_pc);
    chk("sk_busy", bus.busy, 0);
  endtask

  task automatic do_reset_mid();
    idle_in();
    bus.fetch_start = 1'b1;
    step();
    bus.fetch_start = 1'b0;
    chk("rm_busy_pre", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("rm_busy", bus.busy, 0);
    chk("rm_rd", bus.mem_rd, 0);
    chk("rm_pc", bus.pc, 16'h0000);
    chk("rm_inst", bus.inst, 16'h0000);
    chk("rm_valid", bus.inst_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    exp_pc = 16'h0000;
    exp_inst = 16'h0000;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0000] = 8'h12;
    mem[16'h0001] = 8'h34;
    reset = 1'b1;
    idle_in();
    exp_pc = 16'h0000;
    exp_inst = 16'h0000;
    @(negedge clock);
    @(negedge clock);
    chk("rst_pc", bus.pc, 16'h0000);
    chk("rst_inst", bus.inst, 16'h0000);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd", bus.mem_rd, 0);
    chk("rst_addr", bus.mem_addr, 16'h0000);
    chk("rst_valid", bus.inst_valid, 0);
    reset = 1'b0;
    @(negedge clock);

    do_fetch(0, 0);
    chk("t1_inst", bus.inst, 16'h1234);
    do_load(16'h0000);
    do_fetch(3, 3);
    chk("t2_inst", bus.inst, 16'h1234);
    chk("t2_pc", bus.pc, 16'h0002);

    mem[16'hFFFF] = 8'hAB;
    mem[16'h0000] = 8'hCD;
    do_load(16'hFFFF);
    do_fetch(0, 1);
    chk("t3_inst", bus.inst, 16'hABCD);
    chk("t3_pc", bus.pc, 16'h0001);
    do_load(16'hFFFE);
    do_skip();
    chk("t3_skip", bus.pc, 16'h0000);
    do_load(16'hFFFF);
    do_skip();
    chk("t3_skip1", bus.pc, 16'h0001);

    do_abort(1'b1, 0, 16'h0100);
    chk("t4_pc", bus.pc, 16'h0100);
    chk("t4_inst", bus.inst, 16'hABCD);

    idle_in();
    bus.pc_load = 1'b1;
    bus.skip = 1'b1;
    bus.fetch_start = 1'b1;
    bus.pc_load_value = 16'h0200;
    step();
    idle_in();
    exp_pc = 16'h0200;
    chk("t5_pc", bus.pc, 16'h0200);
    chk("t5_busy", bus.busy, 0);
    bus.skip = 1'b1;
    bus.fetch_start = 1'b1;
    step();
    idle_in();
    exp_pc = 16'h0202;
    chk("t5_skip_pc", bus.pc, 16'h0202);
    chk("t5_skip_busy", bus.busy, 0);

    do_reset_mid();

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0, 1: do_fetch($urandom_range(0, 3), $urandom_range(0, 3));
        2: do_load(($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2))
                                                : 16'($urandom));
        3: do_skip();
        4: do_abort(1'($urandom), $urandom_range(0, 2), 16'($urandom));
        default: if ($urandom_range(0, 9) == 0) do_reset_mid();
                 else do_fetch(0, 0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
